// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and encodings for the memory bus arbiter
// Purpose: FSM state encoding, mem_seg tag values, requester indices and
//          the small helpers that decode the CPU segment lines.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [1:0] SEG_CODE  = 2'd0;
  localparam logic [1:0] SEG_DATA  = 2'd1;
  localparam logic [1:0] SEG_STACK = 2'd2;
  localparam logic [1:0] SEG_DMA   = 2'd3;

  // Bit positions inside the arbiter req/grant vectors.
  localparam int REQ_CPU = 0;
  localparam int REQ_DMA = 1;

  // Segment lines packed as {stack, data, code}.
  function automatic logic seg_onehot(input logic [2:0] segs);
    return (segs == 3'b001) || (segs == 3'b010) || (segs == 3'b100);
  endfunction

  function automatic logic [1:0] seg_encode(input logic [2:0] segs);
    logic [1:0] tag;
    case (segs)
      3'b010:  tag = SEG_DATA;
      3'b100:  tag = SEG_STACK;
      default: tag = SEG_CODE;
    endcase
    return tag;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter for the memory bus
// Purpose: grants one of two level-held requesters; on contention the one
//          that did not win last time is granted.
// Ports:
//   i_clk     clock
//   i_rst     synchronous active-high reset (last grant -> DMA)
//   i_req     request vector, bit REQ_CPU / REQ_DMA
//   i_update  record o_grant as the last grant at this edge
//   o_grant   one-hot grant, combinational from i_req and history
module rr_arb2
  import mem_bus_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic [1:0] o_grant
);

  // 1 = DMA held the bus last; reset value makes the CPU win first contention.
  logic r_last_dma;

  always_comb begin
    o_grant          = 2'b00;
    o_grant[REQ_CPU] = i_req[REQ_CPU] && (!i_req[REQ_DMA] || r_last_dma);
    o_grant[REQ_DMA] = i_req[REQ_DMA] && (!i_req[REQ_CPU] || !r_last_dma);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_dma <= 1'b1;
    end else if (i_update) begin
      r_last_dma <= o_grant[REQ_DMA];
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - CPU/DMA arbiter and wait-state sequencer for the external bus
// Purpose: shares the 16-bit memory bus between the CPU and a DMA/debug
//          requester, holds strobes for WAIT_STATES+1 cycles, and returns a
//          one-cycle ready pulse (with read data) to the granted requester.
// Ports:
//   sys_clk, sys_rst                   clock, synchronous active-high reset
//   cpu_load/cpu_store/cpu_*_seg       CPU request and segment select
//   cpu_addr, cpu_wdata                CPU address and write data
//   cpu_ready, cpu_rdata               CPU completion pulse and read data
//   dma_req/dma_we/dma_addr/dma_wdata  second requester access
//   dma_ready, dma_rdata               DMA completion pulse and read data
//   mem_addr/mem_wdata/mem_rdata       external memory bus
//   mem_oe, mem_we, mem_seg            strobes and segment tag
//   bus_err                            malformed CPU request pulse
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cpu_load,
  input  logic              cpu_store,
  input  logic              cpu_code_seg,
  input  logic              cpu_data_seg,
  input  logic              cpu_stack_seg,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ready,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [1:0]        mem_seg,
  output logic              bus_err
);

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_we;
  logic              r_err;
  logic              r_owner_dma;
  logic [1:0]        r_seg;

  logic [2:0]        w_cpu_segs;
  logic              w_cpu_ok;
  logic [1:0]        w_grant;
  logic              w_start;
  logic              w_malformed;
  logic              w_access;
  logic              w_done;

  assign w_cpu_segs = {cpu_stack_seg, cpu_data_seg, cpu_code_seg};
  assign w_cpu_ok   = (cpu_load ^ cpu_store) && seg_onehot(w_cpu_segs);

  // History only advances on a real memory cycle, not on a malformed reject.
  rr_arb2 u_arb (
    .i_clk    (sys_clk),
    .i_rst    (sys_rst),
    .i_req    ({dma_req, cpu_load | cpu_store}),
    .i_update (w_start),
    .o_grant  (w_grant)
  );

  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_malformed = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant[REQ_CPU] && !w_cpu_ok) begin
          w_malformed = 1'b1;
          w_next      = ST_DONE;
        end else if (w_grant != 2'b00) begin
          w_start = 1'b1;
          w_next  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_owner_dma <= 1'b0;
      r_seg       <= SEG_CODE;
    end else begin
      r_state <= w_next;
      if (w_start || w_malformed) begin
        r_owner_dma <= w_grant[REQ_DMA];
        r_err       <= w_malformed;
        r_cnt       <= 4'(WAIT_STATES);
        r_rdata     <= '0;
        if (w_grant[REQ_DMA]) begin
          r_addr  <= dma_addr;
          r_wdata <= dma_wdata;
          r_we    <= dma_we;
          r_seg   <= SEG_DMA;
        end else begin
          r_addr  <= cpu_addr;
          r_wdata <= cpu_wdata;
          r_we    <= cpu_store;
          r_seg   <= seg_encode(w_cpu_segs);
        end
      end else if (r_state == ST_ACCESS) begin
        if (r_cnt == 4'd0) begin
          // Final strobe edge: read data is valid on the bus now.
          r_rdata <= r_we ? '0 : mem_rdata;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  assign w_access  = (r_state == ST_ACCESS);
  assign w_done    = (r_state == ST_DONE);
  assign mem_oe    = w_access && !r_we;
  assign mem_we    = w_access && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_seg   = r_seg;
  assign cpu_ready = w_done && !r_owner_dma;
  assign dma_ready = w_done && r_owner_dma;
  assign cpu_rdata = cpu_ready ? r_rdata : '0;
  assign dma_rdata = dma_ready ? r_rdata : '0;
  assign bus_err   = w_done && r_err;

endmodule
